// File: rtl/iob_axis2axi_wr_if.sv
// rtl/iob_axis2axi_wr_if.sv - AXI4 write-channel bundle (AW/W/B) between a write master and AXI memory
interface iob_axis2axi_wr_if #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 16,
  parameter int ID_WIDTH   = 8,
  parameter int LEN_WIDTH  = 8
);
  logic [ID_WIDTH-1:0]     awid;
  logic [ADDR_WIDTH-1:0]   awaddr;
  logic [LEN_WIDTH-1:0]    awlen;
  logic [2:0]              awsize;
  logic [1:0]              awburst;
  logic                    awlock;
  logic [3:0]              awcache;
  logic [2:0]              awprot;
  logic [3:0]              awqos;
  logic                    awvalid;
  logic                    awready;
  logic [DATA_WIDTH-1:0]   wdata;
  logic [DATA_WIDTH/8-1:0] wstrb;
  logic                    wlast;
  logic                    wvalid;
  logic                    wready;
  logic [ID_WIDTH-1:0]     bid;
  logic [1:0]              bresp;
  logic                    bvalid;
  logic                    bready;

  modport master (
    output awid, awaddr, awlen, awsize, awburst, awlock, awcache, awprot, awqos, awvalid,
    output wdata, wstrb, wlast, wvalid, bready,
    input  awready, wready, bid, bresp, bvalid
  );

  modport slave (
    input  awid, awaddr, awlen, awsize, awburst, awlock, awcache, awprot, awqos, awvalid,
    input  wdata, wstrb, wlast, wvalid, bready,
    output awready, wready, bid, bresp, bvalid
  );
endinterface

// File: rtl/iob_axis2axi_wr.sv
// rtl/iob_axis2axi_wr.sv - stream-to-AXI4 write master issuing 4 KB-safe INCR bursts, one outstanding
module iob_axis2axi_wr #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 16,
  parameter int ID_WIDTH   = 8,
  parameter int LEN_WIDTH  = 8,
  parameter int MAX_BURST  = 16,
  parameter int CNT_WIDTH  = 16
) (
  input  logic                  clk_i,
  input  logic                  rst_n_i,
  input  logic                  start_i,
  input  logic [ADDR_WIDTH-1:0] addr_i,
  input  logic [CNT_WIDTH-1:0]  len_i,
  output logic                  busy_o,
  output logic                  done_o,
  output logic                  err_o,
  input  logic [DATA_WIDTH-1:0] s_data_i,
  input  logic                  s_valid_i,
  output logic                  s_ready_o,
  iob_axis2axi_wr_if.master     axi
);
  localparam int SZ = $clog2(DATA_WIDTH / 8);
  localparam int BW = LEN_WIDTH + 1;
  localparam logic [ADDR_WIDTH-1:0] ADDR_MASK = ADDR_WIDTH'((1 << SZ) - 1);

  typedef enum logic [1:0] {S_IDLE, S_ADDR, S_DATA, S_RESP} state_t;

  state_t                state_q, state_d;
  logic [ADDR_WIDTH-1:0] addr_q;
  logic [CNT_WIDTH-1:0]  remaining_q;
  logic [BW-1:0]         beats_q;
  logic [BW-1:0]         beat_cnt_q;
  logic                  err_q;
  logic                  done_q;
  logic [BW-1:0]         beats_c;
  logic [31:0]           rem_w, page_w, beats_w;
  logic                  w_fire;
  logic                  last_burst;
  logic                  unused_bid;

  // Burst size: remaining beats, clipped to MAX_BURST and to the beats left in the current 4 KB page.
  always_comb begin
    rem_w   = 32'(remaining_q);
    page_w  = (32'd4096 - 32'(addr_q[11:0])) >> SZ;
    beats_w = rem_w;
    if (beats_w > 32'(MAX_BURST)) beats_w = 32'(MAX_BURST);
    if (beats_w > page_w)         beats_w = page_w;
    beats_c = BW'(beats_w);
  end

  assign w_fire     = axi.wvalid & axi.wready;
  assign last_burst = (remaining_q == CNT_WIDTH'(beats_q));
  assign unused_bid = ^axi.bid;

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) state_q <= S_IDLE;
    else          state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE: if (start_i && len_i != '0) state_d = S_ADDR;
      S_ADDR: if (axi.awready) state_d = S_DATA;
      S_DATA: if (w_fire && beat_cnt_q == BW'(1)) state_d = S_RESP;
      S_RESP: if (axi.bvalid) state_d = last_burst ? S_IDLE : S_ADDR;
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    busy_o      = (state_q != S_IDLE);
    axi.awvalid = (state_q == S_ADDR);
    axi.wvalid  = (state_q == S_DATA) & s_valid_i;
    axi.wlast   = (state_q == S_DATA) & (beat_cnt_q == BW'(1));
    s_ready_o   = (state_q == S_DATA) & axi.wready;
    axi.bready  = (state_q == S_RESP);
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      addr_q      <= '0;
      remaining_q <= '0;
      beats_q     <= '0;
      beat_cnt_q  <= '0;
      err_q       <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        S_IDLE: if (start_i) begin
          err_q <= 1'b0;
          if (len_i == '0) begin
            done_q <= 1'b1;
          end else begin
            addr_q      <= addr_i & ~ADDR_MASK;
            remaining_q <= len_i;
          end
        end
        S_ADDR: if (axi.awready) begin
          beats_q    <= beats_c;
          beat_cnt_q <= beats_c;
        end
        S_DATA: if (w_fire) beat_cnt_q <= beat_cnt_q - BW'(1);
        // A failed response is recorded but the remaining bursts still go out.
        S_RESP: if (axi.bvalid) begin
          if (axi.bresp != 2'b00) err_q <= 1'b1;
          remaining_q <= remaining_q - CNT_WIDTH'(beats_q);
          addr_q      <= addr_q + (ADDR_WIDTH'(beats_q) << SZ);
          done_q      <= last_burst;
        end
        default: ;
      endcase
    end
  end

  assign done_o      = done_q;
  assign err_o       = err_q;
  assign axi.awid    = '0;
  assign axi.awaddr  = addr_q;
  assign axi.awlen   = LEN_WIDTH'(beats_c - BW'(1));
  assign axi.awsize  = 3'(SZ);
  assign axi.awburst = 2'b01;
  assign axi.awlock  = 1'b0;
  assign axi.awcache = 4'b0011;
  assign axi.awprot  = 3'b000;
  assign axi.awqos   = 4'b0000;
  assign axi.wdata   = s_data_i;
  assign axi.wstrb   = '1;
endmodule
